// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//
// Writeback arbiter for the register file's single write port. The ALU pipe
// and the memory/load pipe each push {addr, data, tag} write requests through
// a valid/ready handshake into a DEPTH-entry FIFO of their own. Every cycle
// the arbiter pops at most one head entry, choosing the older tag in program
// order, and registers it onto the register file write port.
//
// Ports:
//   CLK, RESET                 clock; synchronous active-high reset
//   ALU_VALID/READY/ADDR/DATA/TAG  ALU writeback source (valid/ready)
//   MEM_VALID/READY/ADDR/DATA/TAG  memory writeback source (valid/ready)
//   WB_WRITE, WB_ADDR, WB_DATA     registered register file write port
//   PENDING                    per-register pending-write vector
//                              (present only when WB_PENDING_EN is defined)
//
// Build option: define WB_PENDING_EN to add the PENDING output and the
// per-entry address compare logic behind it.

module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALU_VALID,
    output logic              ALU_READY,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    input  logic [TAG_W-1:0]  ALU_TAG,
    input  logic              MEM_VALID,
    output logic              MEM_READY,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    input  logic [TAG_W-1:0]  MEM_TAG,
    output logic              WB_WRITE,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic [DATA_W-1:0] WB_DATA
`ifdef WB_PENDING_EN
    ,
    output logic [31:0]       PENDING
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int NSRC    = 2;
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

    logic [NSRC-1:0]   in_valid;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   not_empty;
    logic [ADDR_W-1:0] in_addr   [NSRC];
    logic [DATA_W-1:0] in_data   [NSRC];
    logic [TAG_W-1:0]  in_tag    [NSRC];
    logic [ADDR_W-1:0] head_addr [NSRC];
    logic [DATA_W-1:0] head_data [NSRC];
    logic [TAG_W-1:0]  head_tag  [NSRC];
`ifdef WB_PENDING_EN
    logic [31:0]       src_pending [NSRC];
`endif

    assign in_valid         = {MEM_VALID, ALU_VALID};
    assign in_addr[SRC_ALU] = ALU_ADDR;
    assign in_data[SRC_ALU] = ALU_DATA;
    assign in_tag[SRC_ALU]  = ALU_TAG;
    assign in_addr[SRC_MEM] = MEM_ADDR;
    assign in_data[SRC_MEM] = MEM_DATA;
    assign in_tag[SRC_MEM]  = MEM_TAG;
    assign ALU_READY        = src_ready[SRC_ALU];
    assign MEM_READY        = src_ready[SRC_MEM];

    // One FIFO per source. Storage is not reset: a zero count is what makes
    // the entries invalid, so dropping the queue on reset is just clearing it.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [ADDR_W-1:0] addr_mem [DEPTH];
            logic [DATA_W-1:0] data_mem [DEPTH];
            logic [TAG_W-1:0]  tag_mem  [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]  count_q, count_d;

            // Ready looks only at the registered count, so a full queue stays
            // not-ready even in a cycle where its head is being popped.
            assign src_ready[gi] = (count_q < CNT_W'(DEPTH)) && !RESET;
            assign push[gi]      = in_valid[gi] && src_ready[gi];
            assign not_empty[gi] = (count_q != '0);
            assign head_addr[gi] = addr_mem[rd_ptr_q];
            assign head_data[gi] = data_mem[rd_ptr_q];
            assign head_tag[gi]  = tag_mem[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push[gi]) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (push[gi] && !pop[gi]) begin
                    count_d = count_q + CNT_W'(1);
                end else if (!push[gi] && pop[gi]) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge CLK) begin
                if (push[gi]) begin
                    addr_mem[wr_ptr_q] <= in_addr[gi];
                    data_mem[wr_ptr_q] <= in_data[gi];
                    tag_mem[wr_ptr_q]  <= in_tag[gi];
                end
            end

`ifdef WB_PENDING_EN
            // An entry is live when its distance from the read pointer is
            // below the count; live entries flag their non-zero destination.
            logic [31:0] pend_vec;
            always_comb begin
                logic [PTR_W-1:0] offs;
                offs     = '0;
                pend_vec = '0;
                for (int e = 0; e < DEPTH; e++) begin
                    offs = PTR_W'(e) - rd_ptr_q;
                    for (int r = 1; r < 32; r++) begin
                        if (({1'b0, offs} < count_q) &&
                            (addr_mem[e] == ADDR_W'(r))) begin
                            pend_vec[r] = 1'b1;
                        end
                    end
                end
            end
            assign src_pending[gi] = pend_vec;
`endif
        end
    endgenerate

`ifdef WB_PENDING_EN
    assign PENDING = src_pending[SRC_ALU] | src_pending[SRC_MEM];
`endif

    // Program-order selection: ALU is older when the modular tag difference
    // is "negative". Equal tags fall through to MEM.
    logic [TAG_W-1:0] tag_diff;
    logic             alu_older;
    logic             sel_alu;
    logic             sel_mem;

    assign tag_diff  = head_tag[SRC_ALU] - head_tag[SRC_MEM];
    assign alu_older = tag_diff[TAG_W-1];
    assign sel_alu   = not_empty[SRC_ALU] && (!not_empty[SRC_MEM] || alu_older);
    assign sel_mem   = not_empty[SRC_MEM] && !sel_alu;
    assign pop       = {sel_mem, sel_alu};

    // Registered write port. Address/data load on every issue, including the
    // discarded x0 writes, and hold when nothing is issued.
    logic              wb_write_q, wb_write_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    always_comb begin
        wb_write_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (sel_alu) begin
            wb_addr_d  = head_addr[SRC_ALU];
            wb_data_d  = head_data[SRC_ALU];
            wb_write_d = (head_addr[SRC_ALU] != '0);
        end else if (sel_mem) begin
            wb_addr_d  = head_addr[SRC_MEM];
            wb_data_d  = head_data[SRC_MEM];
            wb_write_d = (head_addr[SRC_MEM] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign WB_WRITE = wb_write_q;
    assign WB_ADDR  = wb_addr_q;
    assign WB_DATA  = wb_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter (default parameters). A queue-based model of
// the two sources predicts the write port, READY and PENDING each cycle;
// directed scenarios add literal expectations that pin the model's timing.

module tb_reg_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, wb_addr;
    logic [31:0] alu_data, mem_data, wb_data;
    logic [3:0]  alu_tag, mem_tag;
    logic        wb_write;
`ifdef WB_PENDING_EN
    logic [31:0] pending;
`endif

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .CLK      (clk),
        .RESET    (rst),
        .ALU_VALID(alu_valid),
        .ALU_READY(alu_ready),
        .ALU_ADDR (alu_addr),
        .ALU_DATA (alu_data),
        .ALU_TAG  (alu_tag),
        .MEM_VALID(mem_valid),
        .MEM_READY(mem_ready),
        .MEM_ADDR (mem_addr),
        .MEM_DATA (mem_data),
        .MEM_TAG  (mem_tag),
        .WB_WRITE (wb_write),
        .WB_ADDR  (wb_addr),
        .WB_DATA  (wb_data)
`ifdef WB_PENDING_EN
        ,
        .PENDING  (pending)
`endif
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  tag;
    } ent_t;

    ent_t        q_alu[$];
    ent_t        q_mem[$];
    logic        exp_write = 1'b0;
    logic [4:0]  exp_addr  = '0;
    logic [31:0] exp_data  = '0;
    logic [31:0] rf [32];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Older in program order: the other tag is less than half the tag
    // space ahead of this one, modulo 16.
    function automatic bit alu_is_older(input logic [3:0] a, input logic [3:0] m);
        int d;
        d = (int'(a) - int'(m) + 16) % 16;
        return d >= 8;
    endfunction

`ifdef WB_PENDING_EN
    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (q_alu[i]) if (q_alu[i].addr != 0) p[q_alu[i].addr] = 1'b1;
        foreach (q_mem[i]) if (q_mem[i].addr != 0) p[q_mem[i].addr] = 1'b1;
        return p;
    endfunction
`endif

    // Advance the model across one rising edge using the inputs in force.
    task automatic model_step();
        ent_t e;
        bit   acc_a, acc_m, take_a, take_m;
        if (rst) begin
            q_alu.delete();
            q_mem.delete();
            exp_write = 1'b0;
            exp_addr  = '0;
            exp_data  = '0;
            return;
        end
        acc_a  = alu_valid && (q_alu.size() < DEPTH);
        acc_m  = mem_valid && (q_mem.size() < DEPTH);
        take_a = (q_alu.size() > 0) &&
                 ((q_mem.size() == 0) || alu_is_older(q_alu[0].tag, q_mem[0].tag));
        take_m = (q_mem.size() > 0) && !take_a;
        exp_write = 1'b0;
        if (take_a || take_m) begin
            e = take_a ? q_alu.pop_front() : q_mem.pop_front();
            exp_addr  = e.addr;
            exp_data  = e.data;
            exp_write = (e.addr != 0);
            $display("issue %s addr=%0d data=0x%08h tag=%0d at %0t",
                     take_a ? "ALU" : "MEM", e.addr, e.data, e.tag, $time);
        end
        if (acc_a) q_alu.push_back('{addr: alu_addr, data: alu_data, tag: alu_tag});
        if (acc_m) q_mem.push_back('{addr: mem_addr, data: mem_data, tag: mem_tag});
    endtask

    // Per-cycle comparison of every meaningful output against the model;
    // also plays the register file, which writes on the falling edge.
    task automatic compare_all();
        check("cyc_wb_write", 32'(wb_write), 32'(exp_write));
        check("cyc_wb_addr", 32'(wb_addr), 32'(exp_addr));
        check("cyc_wb_data", wb_data, exp_data);
        check("cyc_alu_ready", 32'(alu_ready), 32'(!rst && (q_alu.size() < DEPTH)));
        check("cyc_mem_ready", 32'(mem_ready), 32'(!rst && (q_mem.size() < DEPTH)));
`ifdef WB_PENDING_EN
        check("cyc_pending", pending, model_pending());
`endif
        if (wb_write === 1'b1) rf[wb_addr] = wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] t);
        alu_valid = v; alu_addr = a; alu_data = d; alu_tag = t;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] t);
        mem_valid = v; mem_addr = a; mem_data = d; mem_tag = t;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with both sources offering writes.
        rst = 1'b1;
        set_alu(1'b1, 5'd9, 32'h0000_0009, 4'd0);
        set_mem(1'b1, 5'd8, 32'h0000_0008, 4'd0);
        repeat (2) begin
            tick();
            check("rst_alu_ready", 32'(alu_ready), 32'd0);
            check("rst_mem_ready", 32'(mem_ready), 32'd0);
            check("rst_wb_write", 32'(wb_write), 32'd0);
        end
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        idle();
        tick();
        check("rel_alu_ready", 32'(alu_ready), 32'd1);
        check("rel_mem_ready", 32'(mem_ready), 32'd1);
        check("rel_wb_write", 32'(wb_write), 32'd0);

        // Single write: issued one edge after acceptance, one-cycle pulse.
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF, 4'd3);
        tick();
        idle();
        tick();
        check("single_write", 32'(wb_write), 32'd1);
        check("single_addr", 32'(wb_addr), 32'd5);
        check("single_data", wb_data, 32'hDEAD_BEEF);
        tick();
        check("single_write_off", 32'(wb_write), 32'd0);

        // Wrapped tags: MEM 14 is older than ALU 1.
        set_mem(1'b1, 5'd2, 32'h22, 4'd14);
        set_alu(1'b1, 5'd2, 32'h11, 4'd1);
        tick();
        idle();
        tick();
        check("wrap_first_data", wb_data, 32'h22);
        check("wrap_first_write", 32'(wb_write), 32'd1);
        tick();
        check("wrap_second_data", wb_data, 32'h11);
        check("wrap_second_write", 32'(wb_write), 32'd1);
        check("wrap_rf2", rf[2], 32'h11);

        // ALU older through the MSB of the difference: 15 - 0 = 15.
        set_alu(1'b1, 5'd20, 32'h0A20, 4'd15);
        set_mem(1'b1, 5'd21, 32'h0A21, 4'd0);
        tick();
        idle();
        tick();
        check("older_first_addr", 32'(wb_addr), 32'd20);
        tick();
        check("older_second_addr", 32'(wb_addr), 32'd21);

        // Equal tags: MEM wins.
        set_alu(1'b1, 5'd9, 32'h99, 4'd13);
        set_mem(1'b1, 5'd8, 32'h88, 4'd13);
        tick();
        idle();
        tick();
        check("eq_first_addr", 32'(wb_addr), 32'd8);
        tick();
        check("eq_second_addr", 32'(wb_addr), 32'd9);

        // Backpressure: older MEM traffic fills the ALU queue.
        set_mem(1'b1, 5'd10, 32'hA0, 4'd4);
        set_alu(1'b1, 5'd12, 32'hC0, 4'd6);
        tick();
        set_mem(1'b1, 5'd11, 32'hB0, 4'd5);
        set_alu(1'b1, 5'd13, 32'hD0, 4'd7);
        tick();
        check("bp_ready_full", 32'(alu_ready), 32'd0);
        check("bp_issue_m4", 32'(wb_addr), 32'd10);
        set_mem(1'b0, 5'd0, 32'h0, 4'd0);
        set_alu(1'b1, 5'd14, 32'hE0, 4'd8);
        tick();
        check("bp_ready_still", 32'(alu_ready), 32'd0);
        check("bp_issue_m5", 32'(wb_addr), 32'd11);
        tick();
        check("bp_issue_a6", 32'(wb_addr), 32'd12);
        check("bp_issue_a6_data", wb_data, 32'hC0);
        check("bp_ready_back", 32'(alu_ready), 32'd1);
        tick();
        idle();
        check("bp_issue_a7", 32'(wb_addr), 32'd13);
        tick();
        check("bp_issue_a8", 32'(wb_addr), 32'd14);
        check("bp_issue_a8_data", wb_data, 32'hE0);
        check("bp_issue_a8_write", 32'(wb_write), 32'd1);

        // x0 write is popped and discarded, address/data still load.
        set_alu(1'b1, 5'd0, 32'h1234, 4'd9);
        tick();
        idle();
        tick();
        check("x0_write", 32'(wb_write), 32'd0);
        check("x0_addr", 32'(wb_addr), 32'd0);
        check("x0_data", wb_data, 32'h1234);
`ifdef WB_PENDING_EN
        check("x0_pending", pending, 32'd0);
`endif
        tick();
        check("x0_ready", 32'(alu_ready), 32'd1);

        // Pending: addr 7 held back by two older MEM entries.
        set_mem(1'b1, 5'd3, 32'h33, 4'd10);
        set_alu(1'b1, 5'd7, 32'h77, 4'd12);
        tick();
`ifdef WB_PENDING_EN
        check("pend_accept", pending, 32'h0000_0088);
`endif
        set_mem(1'b1, 5'd4, 32'h44, 4'd11);
        set_alu(1'b0, 5'd0, 32'h0, 4'd0);
        tick();
        idle();
`ifdef WB_PENDING_EN
        check("pend_two_mem", pending, 32'h0000_0090);
`endif
        check("pend_issue_3", 32'(wb_addr), 32'd3);
        tick();
        check("pend_issue_4", 32'(wb_addr), 32'd4);
`ifdef WB_PENDING_EN
        check("pend_only_7", pending, 32'h0000_0080);
`endif
        tick();
        check("pend_issue_7", 32'(wb_addr), 32'd7);
`ifdef WB_PENDING_EN
        check("pend_clear", pending, 32'd0);
`endif

        // Reset mid-operation drops queued entries with no writeback.
        set_alu(1'b1, 5'd25, 32'h25, 4'd1);
        set_mem(1'b1, 5'd26, 32'h26, 4'd2);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_write", 32'(wb_write), 32'd0);
        check("mid_rst_addr", 32'(wb_addr), 32'd0);
        rst = 1'b0;
        idle();
        tick();
        check("mid_after_write", 32'(wb_write), 32'd0);
        tick();
        check("mid_after_write2", 32'(wb_write), 32'd0);
        check("mid_after_ready", 32'(alu_ready), 32'd1);

        check("final_rf5", rf[5], 32'hDEAD_BEEF);
        check("final_rf2", rf[2], 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
